// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and default framing constants.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int CLKS_PER_BIT_DEF = 104;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous pin inputs; reset value chosen per pin's idle level.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability filter: pin passes through two flops before use.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, valid/ack output handshake and error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_rx,
    input  logic              i_ack,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_frame_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic              w_rx_s;
    uart_state_e       r_state;
    uart_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_nxt;
    logic [DATA_W-1:0] r_shift;
    logic              w_shift_en;
    logic              w_load;
    logic              w_ferr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;
    logic              r_busy;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_d    (i_rx),
        .o_q    (w_rx_s)
    );

    // State, bit-timing counter and bit index registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_bit_idx <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    // Next-state logic; every sample point is the last count of its bit window.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_en    = 1'b0;
        w_load        = 1'b0;
        w_ferr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt     = CNT_ZERO;
                    w_bit_idx_nxt = 3'd0;
                    // A start bit that has gone high again by mid-bit is treated as noise.
                    if (!w_rx_s) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt     = CNT_ZERO;
                    w_shift_en    = 1'b1;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (w_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_BREAK: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BREAK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Data shift register, filled LSB first at each data sample point.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_shift <= {DATA_W{1'b0}};
        end else if (w_shift_en) begin
            r_shift[r_bit_idx] <= w_rx_s;
        end
    end

    // Output handshake: a new byte wins over a simultaneous acknowledge.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_data      <= {DATA_W{1'b0}};
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_load & r_valid & ~i_ack;
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (i_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 83 ns clock, 8681 ns bit time, event counters plus direct output checks.
`timescale 1ns/100ps
module tb_uart_rx;

    localparam real BIT_NS = 8681.0;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rx;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         valid_rises = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] rx_q[$];
    bit         ack_en = 1'b0;
    logic       prev_valid = 1'b0;

    uart_rx dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_rx        (rx),
        .i_ack       (ack),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (ferr),
        .o_overrun   (ovr),
        .o_busy      (busy)
    );

    initial forever #41.5 clk = ~clk;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Event monitor: counts rising valids, error pulses and logs each newly presented byte.
    initial forever begin
        @(negedge clk);
        if (valid === 1'b1 && prev_valid !== 1'b1) begin
            valid_rises++;
            rx_q.push_back(data);
        end
        if (ferr === 1'b1) ferr_cnt++;
        if (ovr === 1'b1) ovr_cnt++;
        prev_valid = valid;
    end

    // Consumer model: one-cycle ack for each presented byte while enabled.
    initial forever begin
        @(negedge clk);
        if (ack_en) begin
            if (valid === 1'b1 && ack !== 1'b1) ack = 1'b1;
            else ack = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int i);
        if (i < rx_q.size()) return {24'h0, rx_q[i]};
        else return 32'hDEAD_BEEF;
    endfunction

    task automatic clear_counts();
        valid_rises = 0;
        ferr_cnt    = 0;
        ovr_cnt     = 0;
        rx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = stop_v;
        #(BIT_NS);
    endtask

    // Clock-aligned frame, started on a negedge, 104 cycles per bit.
    task automatic sync_send(input logic [7:0] b);
        rx = 1'b0;
        repeat (104) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (104) @(negedge clk);
        end
        rx = 1'b1;
        repeat (104) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 3000 && valid !== 1'b1; i++) @(negedge clk);
        chk(tag, valid, 1);
    endtask

    logic [7:0] exp_b2b [5] = '{8'h33, 8'hEE, 8'h00, 8'hFF, 8'h55};
    logic [7:0] b33 = 8'h33;

    initial begin
        rx   = 1'b1;
        ack  = 1'b0;
        nrst = 1'b0;
        #1;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte, manual acknowledge.
        clear_counts();
        send_byte(8'h11, 1'b1);
        wait_valid("t1_valid");
        chk("t1_data", data, 8'h11);
        chk("t1_rises", valid_rises, 1);
        chk("t1_ferr", ferr_cnt, 0);
        chk("t1_ovr", ovr_cnt, 0);
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        chk("t1_ack_clr", valid, 0);
        @(negedge clk);
        ack = 1'b0;

        // Back-to-back frames with automatic acknowledge.
        ack_en = 1'b1;
        clear_counts();
        fork
            for (int k = 0; k < 5; k++) send_byte(exp_b2b[k], 1'b1);
            begin
                #(BIT_NS * 5.0);
                chk("t2_busy_mid", busy, 1);
            end
        join
        #(BIT_NS);
        chk("t2_rises", valid_rises, 5);
        for (int k = 0; k < 5; k++) chk($sformatf("t2_byte%0d", k), q_at(k), {24'h0, exp_b2b[k]});
        chk("t2_ferr", ferr_cnt, 0);
        chk("t2_ovr", ovr_cnt, 0);

        // Framing error on a held-low line, then recovery.
        clear_counts();
        send_byte(8'h33, 1'b0);
        #(BIT_NS * 2.0);
        rx = 1'b1;
        #(BIT_NS);
        chk("t3_ferr", ferr_cnt, 1);
        chk("t3_valid", valid, 0);
        chk("t3_rises0", valid_rises, 0);
        send_byte(8'hEE, 1'b1);
        #(BIT_NS);
        chk("t3_rises1", valid_rises, 1);
        chk("t3_byte", q_at(0), 8'hEE);
        chk("t3_ferr_end", ferr_cnt, 1);

        // Overrun, then an acknowledge landing exactly on the load cycle.
        ack_en = 1'b0;
        ack    = 1'b0;
        clear_counts();
        send_byte(8'h11, 1'b1);
        send_byte(8'hEE, 1'b1);
        #(BIT_NS);
        chk("t4_ovr", ovr_cnt, 1);
        chk("t4_data", data, 8'hEE);
        chk("t4_valid", valid, 1);
        chk("t4_rises", valid_rises, 1);
        @(negedge clk);
        fork
            sync_send(8'h55);
            begin
                repeat (990) @(posedge clk);
                @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        join
        chk("t4b_ovr", ovr_cnt, 1);
        chk("t4b_valid", valid, 1);
        chk("t4b_data", data, 8'h55);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        chk("t4b_clr", valid, 0);

        // Start-bit glitch of 20 cycles.
        ack_en = 1'b1;
        clear_counts();
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_busy", busy, 1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        chk("t5_idle", busy, 0);
        chk("t5_rises", valid_rises, 0);
        chk("t5_ferr", ferr_cnt, 0);

        // Reset in the middle of a byte, then a clean byte.
        clear_counts();
        @(negedge clk);
        rx = 1'b0;
        repeat (104) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx = b33[i];
            repeat (104) @(negedge clk);
        end
        rx = b33[5];
        repeat (52) @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        nrst = 1'b0;
        #1;
        chk("t6_data", data, 0);
        chk("t6_valid", valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ferr", ferr, 0);
        chk("t6_ovr", ovr, 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h11, 1'b1);
        #(BIT_NS);
        chk("t6_rises", valid_rises, 1);
        chk("t6_byte", q_at(0), 8'h11);
        chk("t6_ferr_cnt", ferr_cnt, 0);
        chk("t6_ovr_cnt", ovr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
